// File: rtl/mem_uart_tx_if.sv
// Bus between the output-image reader/UART transmitter and its host + output RAM.
// The slave side is the transmitter; the master side drives requests and RAM read data.
interface mem_uart_tx_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_add;
  logic [ADDR_W-1:0] num_bytes;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_add, num_bytes, mem_data,
    output mem_add, tx, busy, done
  );

  modport master (
    output start, base_add, num_bytes, mem_data,
    input  mem_add, tx, busy, done
  );
endinterface

// File: rtl/mem_uart_tx.sv
// Reads bytes back from the output-image RAM and sends them as 8N1 UART frames, LSB first.
// One RAM read per byte: address in FETCH, data captured at the end of WAIT.
module mem_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned DATA_W       = 8
) (
  input logic          clk,
  input logic          reset,
  mem_uart_tx_if.slave bus_io
);
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_W);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StStart, StData, StStop, StNext
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_add_q, mem_add_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BaudMax);

  always_comb begin
    state_d     = state_q;
    mem_add_d   = mem_add_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    baud_d      = baud_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          if (bus_io.num_bytes != '0) begin
            mem_add_d   = bus_io.base_add;
            remaining_d = bus_io.num_bytes;
            busy_d      = 1'b1;
            state_d     = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        shift_d = bus_io.mem_data;
        baud_d  = '0;
        state_d = StStart;
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitMax) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (remaining_q == ADDR_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StNext;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StNext: begin
        remaining_d = remaining_q - ADDR_W'(1);
        mem_add_d   = mem_add_q + ADDR_W'(1);
        state_d     = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the state being entered so tx itself can be a plain flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_add_q   <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_add_q   <= mem_add_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus_io.mem_add = mem_add_q;
  assign bus_io.tx      = tx_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.done    = done_q;

endmodule

// File: tb/tb_mem_uart_tx.sv
// Bench for mem_uart_tx: a fast instance (4 clocks/bit) for corner cases and a
// 434 clocks/bit instance for a long random burst, both checked by a UART monitor.
module tb_mem_uart_tx;
  localparam int CpbA   = 4;
  localparam int CpbB   = 434;
  localparam int GapCap = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_uart_tx_if #(.ADDR_W(19), .DATA_W(8)) ifa ();
  mem_uart_tx_if #(.ADDR_W(19), .DATA_W(8)) ifb ();

  mem_uart_tx #(.CLKS_PER_BIT(CpbA), .ADDR_W(19), .DATA_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus_io(ifa)
  );
  mem_uart_tx #(.CLKS_PER_BIT(CpbB), .ADDR_W(19), .DATA_W(8)) dut_b (
    .clk(clk), .reset(reset), .bus_io(ifb)
  );

  logic [7:0] ram_a [logic [18:0]];
  logic [7:0] ram_b [logic [18:0]];

  // Synchronous-read RAM models.
  always @(posedge clk) begin
    ifa.mem_data <= ram_a.exists(ifa.mem_add) ? ram_a[ifa.mem_add] : 8'h00;
    ifb.mem_data <= ram_b.exists(ifb.mem_add) ? ram_b[ifb.mem_add] : 8'h00;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ram_rd(input bit s, input logic [18:0] a);
    if (s) return ram_b.exists(a) ? ram_b[a] : 8'h00;
    return ram_a.exists(a) ? ram_a[a] : 8'h00;
  endfunction

  function automatic logic tx_of(input bit s);
    return s ? ifb.tx : ifa.tx;
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic done_of(input bit s);
    return s ? ifb.done : ifa.done;
  endfunction
  function automatic logic [18:0] madd_of(input bit s);
    return s ? ifb.mem_add : ifa.mem_add;
  endfunction
  function automatic int qsize(input bit s);
    return s ? exp_b.size() : exp_a.size();
  endfunction

  task automatic set_start(input bit s, input logic v, input logic [18:0] b, input logic [18:0] n);
    if (s) begin
      ifb.start = v; ifb.base_add = b; ifb.num_bytes = n;
    end else begin
      ifa.start = v; ifa.base_add = b; ifa.num_bytes = n;
    end
  endtask

  // UART monitor: checks every cycle of each frame against the scoreboard byte,
  // decodes mid-bit samples, and measures idle gaps between frames.
  bit         m_in    [2];
  int         m_off   [2];
  int         m_gap   [2];
  bit         m_ok    [2];
  logic [7:0] m_exp   [2];
  logic [7:0] m_dec   [2];
  logic       m_t;
  logic       m_eb;
  int         m_cpb;
  int         m_bn;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_t   = (i == 0) ? ifa.tx : ifb.tx;
      m_cpb = (i == 0) ? CpbA : CpbB;
      if (reset) begin
        m_in[i]  = 1'b0;
        m_gap[i] = GapCap;
      end else if (!m_in[i]) begin
        if (m_t == 1'b0) begin
          if (m_gap[i] < GapCap) chk("inter_frame_gap", m_gap[i], 3);
          chk("frame_expected", (qsize(i != 0) != 0), 1);
          if (i == 0) m_exp[i] = (exp_a.size() != 0) ? exp_a.pop_front() : 8'h00;
          else        m_exp[i] = (exp_b.size() != 0) ? exp_b.pop_front() : 8'h00;
          m_in[i]  = 1'b1;
          m_off[i] = 1;
          m_dec[i] = 8'h00;
          m_ok[i]  = 1'b1;
        end else if (m_gap[i] < GapCap) begin
          m_gap[i]++;
        end
      end else begin
        m_bn = m_off[i] / m_cpb;
        if (m_bn == 0)      m_eb = 1'b0;
        else if (m_bn >= 9) m_eb = 1'b1;
        else                m_eb = m_exp[i][m_bn-1];
        if (m_t !== m_eb) m_ok[i] = 1'b0;
        if (m_bn >= 1 && m_bn <= 8 && (m_off[i] % m_cpb) == m_cpb / 2) m_dec[i][m_bn-1] = m_t;
        m_off[i]++;
        if (m_off[i] == 10 * m_cpb) begin
          m_in[i]  = 1'b0;
          m_gap[i] = 0;
          chk("frame_byte", m_dec[i], m_exp[i]);
          chk("frame_shape_len", m_ok[i], 1);
        end
      end
    end
  end

  // Called just after a negedge. k counts negedges after the accepting clock edge.
  task automatic run_xfer(input bit s, input logic [18:0] base, input logic [18:0] n,
                          input logic [18:0] exp_add, input int exp_lat, input int poke_k,
                          input bit chain);
    int first_low;
    int done_k;
    int busy_bad;
    logic busy_at_done;
    logic [18:0] a;
    for (int j = 0; j < int'(n); j++) begin
      a = base + 19'(j);
      if (s) exp_b.push_back(ram_rd(s, a));
      else   exp_a.push_back(ram_rd(s, a));
    end
    set_start(s, 1'b1, base, n);
    first_low    = 0;
    done_k       = 0;
    busy_bad     = 0;
    busy_at_done = 1'b1;
    for (int k = 1; k <= exp_lat + 50 && done_k == 0; k++) begin
      @(negedge clk);
      if (poke_k != 0 && k == poke_k) set_start(s, 1'b1, 19'h00300, 19'd5);
      else                            set_start(s, 1'b0, base, n);
      if (k == 1 && n != 0) chk("mem_add_latched", madd_of(s), base);
      if (first_low == 0 && tx_of(s) == 1'b0) first_low = k;
      if (done_of(s)) begin
        done_k       = k;
        busy_at_done = busy_of(s);
      end else if (busy_of(s) != (n != 0)) begin
        busy_bad++;
      end
    end
    chk("done_latency", done_k, exp_lat);
    chk("busy_while_active", busy_bad, 0);
    chk("busy_low_at_done", busy_at_done, 0);
    chk("first_start_bit", first_low, (n != 0) ? 3 : 0);
    if (!chain) begin
      @(negedge clk);
      chk("done_one_cycle", done_of(s), 0);
      chk("final_mem_add", madd_of(s), exp_add);
      chk("scoreboard_drained", qsize(s), 0);
      repeat (20) @(negedge clk);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [18:0] base;
    logic [18:0] n;
    logic [18:0] exp_add;
    int          exp_lat;
    int          poke_k;
  } vec_t;

  vec_t vecs [4];
  int   done_cnt;

  initial begin
    // Latency to done: 3 + 10*CPB*n + 3*(n-1); a zero-length request answers on the next edge.
    vecs[0] = '{sel: 1'b0, base: 19'h00010, n: 19'd1, exp_add: 19'h00010, exp_lat: 43,  poke_k: 0};
    vecs[1] = '{sel: 1'b0, base: 19'h7FFFE, n: 19'd3, exp_add: 19'h00000, exp_lat: 129, poke_k: 0};
    vecs[2] = '{sel: 1'b0, base: 19'h00123, n: 19'd0, exp_add: 19'h00000, exp_lat: 1,   poke_k: 0};
    vecs[3] = '{sel: 1'b0, base: 19'h00200, n: 19'd2, exp_add: 19'h00201, exp_lat: 86,  poke_k: 20};

    ram_a[19'h00010] = 8'hA5;
    ram_a[19'h7FFFE] = 8'h01;
    ram_a[19'h7FFFF] = 8'h02;
    ram_a[19'h00000] = 8'h03;
    ram_a[19'h00200] = 8'h3C;
    ram_a[19'h00201] = 8'hC3;
    ram_a[19'h00400] = 8'h11;
    ram_a[19'h00401] = 8'h22;
    ram_a[19'h00402] = 8'h33;
    ram_a[19'h00403] = 8'h44;
    ram_a[19'h00500] = 8'h5A;
    for (int j = 0; j < 16; j++) ram_b[19'h01000 + 19'(j)] = 8'($urandom_range(0, 255));

    reset = 1'b1;
    set_start(1'b0, 1'b0, '0, '0);
    set_start(1'b1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_tx_a", ifa.tx, 1);
    chk("rst_busy_a", ifa.busy, 0);
    chk("rst_done_a", ifa.done, 0);
    chk("rst_mem_add_a", ifa.mem_add, 0);
    chk("rst_tx_b", ifb.tx, 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_xfer(vecs[v].sel, vecs[v].base, vecs[v].n, vecs[v].exp_add, vecs[v].exp_lat,
               vecs[v].poke_k, 1'b0);
    end

    // Reset in the middle of the first byte's data bits of a 4-byte transfer.
    for (int j = 0; j < 4; j++) exp_a.push_back(ram_rd(1'b0, 19'h00400 + 19'(j)));
    set_start(1'b0, 1'b1, 19'h00400, 19'd4);
    @(negedge clk);
    set_start(1'b0, 1'b0, 19'h00400, 19'd4);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", ifa.tx, 1);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_mem_add", ifa.mem_add, 0);
    chk("mid_rst_done", ifa.done, 0);
    reset = 1'b0;
    exp_a.delete();
    done_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifa.done) done_cnt++;
    end
    chk("no_done_after_reset", done_cnt, 0);
    run_xfer(1'b0, 19'h00500, 19'd1, 19'h00500, 43, 0, 1'b0);

    // A new start in the very cycle done pulses is taken without a lost cycle.
    run_xfer(1'b0, 19'h00010, 19'd1, 19'h00010, 43, 0, 1'b1);
    run_xfer(1'b0, 19'h7FFFF, 19'd2, 19'h00000, 86, 0, 1'b0);

    // Full-rate burst of 16 random bytes.
    run_xfer(1'b1, 19'h01000, 19'd16, 19'h0100F, 3 + 10 * CpbB * 16 + 3 * 15, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
